// File: rtl/tdm_demux_1x4_if.sv
// Bus bundle for the 1:4 TDM demultiplexer.
//   din, din_valid, frame_sync : multiplexed sample stream into the demux
//   y0..y3                     : rebuilt channels, held between frames
//   sel                        : next expected slot {s1,s0}
//   frame_valid                : one-cycle pulse when y0..y3 update
//   sync_err                   : one-cycle pulse on a frame_sync violation
// master = stream source / channel consumer side, slave = demux side.
interface tdm_demux_1x4_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic [1:0]       sel;
  logic             frame_valid;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  y0, y1, y2, y3, sel, frame_valid, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y0, y1, y2, y3, sel, frame_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: receive end of a 4:1 time-division mux link.
// Rebuilds four channels from one sample stream (slot 0 marked by
// frame_sync) and presents all four together once per complete frame.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : tdm_demux_1x4_if.slave (din/din_valid/frame_sync in;
//           y0..y3, sel, frame_valid, sync_err out)
module tdm_demux_1x4 #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux_1x4_if.slave bus
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                state;
  // Slots 0..2 wait here; slot 3 goes straight from din to y3 so the
  // whole frame lands on the outputs in a single edge.
  logic [2:0][WIDTH-1:0] shadow;
  logic                  rst_meta_n, rst_sync_n;

  // Assert asynchronously, release synchronously to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_n <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta_n <= 1'b1;
      rst_sync_n <= rst_meta_n;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state           <= HUNT;
      shadow          <= '0;
      bus.y0          <= '0;
      bus.y1          <= '0;
      bus.y2          <= '0;
      bus.y3          <= '0;
      bus.sel         <= 2'd0;
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
    end else begin
      bus.frame_valid <= 1'b0;
      bus.sync_err    <= 1'b0;
      if (bus.din_valid) begin
        unique case (state)
          HUNT: begin
            // Samples before the first frame_sync are dropped silently.
            if (bus.frame_sync) begin
              shadow[0] <= bus.din;
              bus.sel   <= 2'd1;
              state     <= LOCK;
            end
          end
          LOCK: begin
            if (bus.sel == 2'd0) begin
              if (bus.frame_sync) begin
                shadow[0] <= bus.din;
                bus.sel   <= 2'd1;
              end else begin
                // Lost alignment: go back to hunting for frame_sync.
                bus.sync_err <= 1'b1;
                bus.sel      <= 2'd0;
                state        <= HUNT;
              end
            end else if (bus.frame_sync) begin
              // Early sync: abandon the partial frame, restart at slot 0.
              bus.sync_err <= 1'b1;
              shadow[0]    <= bus.din;
              bus.sel      <= 2'd1;
            end else if (bus.sel == 2'd3) begin
              bus.y0          <= shadow[0];
              bus.y1          <= shadow[1];
              bus.y2          <= shadow[2];
              bus.y3          <= bus.din;
              bus.frame_valid <= 1'b1;
              bus.sel         <= 2'd0;
            end else begin
              shadow[bus.sel] <= bus.din;
              bus.sel         <= bus.sel + 2'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
module tb_tdm_demux_1x4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   fv_cnt = 0;
  int   excl_bad = 0;

  always #5 clk = ~clk;

  tdm_demux_1x4_if #(.WIDTH(4)) b4 ();
  tdm_demux_1x4_if #(.WIDTH(1)) b1 ();

  tdm_demux_1x4 #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  tdm_demux_1x4 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs on the WIDTH=4 instance; inputs change
  // 1 time unit after the edge and outputs are read there too.
  task automatic step4(input logic v, input logic fs, input logic [3:0] d);
    b4.din_valid  = v;
    b4.frame_sync = fs;
    b4.din        = d;
    @(posedge clk);
    #1;
    if (b4.frame_valid) fv_cnt++;
    if (b4.frame_valid && b4.sync_err) excl_bad++;
  endtask

  task automatic step1(input logic v, input logic fs, input logic d);
    b1.din_valid  = v;
    b1.frame_sync = fs;
    b1.din        = d;
    @(posedge clk);
    #1;
    if (b1.frame_valid && b1.sync_err) excl_bad++;
  endtask

  function automatic logic [15:0] y4();
    return {b4.y0, b4.y1, b4.y2, b4.y3};
  endfunction

  initial begin
    b4.din_valid = 1'b0; b4.frame_sync = 1'b0; b4.din = '0;
    b1.din_valid = 1'b0; b1.frame_sync = 1'b0; b1.din = '0;

    // Reset held while din is active.
    step4(1, 1, 4'hA);
    step4(1, 0, 4'h5);
    chk("rst_y", y4(), 16'h0000);
    chk("rst_sel", b4.sel, 2'd0);
    chk("rst_fv", b4.frame_valid, 1'b0);
    rst_n = 1'b1;
    step4(0, 0, 0); step4(0, 0, 0); step4(0, 0, 0);

    // HUNT: unsynced sample is dropped without an error.
    step4(1, 0, 4'hF);
    chk("hunt_sel", b4.sel, 2'd0);
    chk("hunt_err", b4.sync_err, 1'b0);

    // WIDTH=1: 0,1,0,1 back to back.
    step1(1, 1, 1'b0);
    step1(1, 0, 1'b1);
    step1(1, 0, 1'b0);
    chk("w1_fv_early", b1.frame_valid, 1'b0);
    step1(1, 0, 1'b1);
    chk("w1_y", {b1.y0, b1.y1, b1.y2, b1.y3}, 4'b0101);
    chk("w1_fv", b1.frame_valid, 1'b1);
    step1(0, 0, 1'b0);
    chk("w1_fv_off", b1.frame_valid, 1'b0);

    // WIDTH=4: frames A,5,3,C and 1,2,3,4 with bubbles.
    fv_cnt = 0;
    step4(1, 1, 4'hA); step4(0, 0, 4'hE);
    chk("sel_after_s0", b4.sel, 2'd1);
    step4(1, 0, 4'h5); step4(0, 1, 4'hE);
    chk("sel_after_s1", b4.sel, 2'd2);
    step4(1, 0, 4'h3); step4(0, 0, 4'hE);
    step4(1, 0, 4'hC);
    chk("f1_y", y4(), 16'hA53C);
    chk("f1_fv", b4.frame_valid, 1'b1);
    chk("f1_sel_wrap", b4.sel, 2'd0);
    step4(0, 0, 0);
    chk("f1_fv_off", b4.frame_valid, 1'b0);
    step4(1, 1, 4'h1); step4(0, 0, 0);
    step4(1, 0, 4'h2);
    chk("f1_held", y4(), 16'hA53C);
    step4(0, 0, 0);
    step4(1, 0, 4'h3); step4(0, 0, 0); step4(0, 0, 0);
    step4(1, 0, 4'h4);
    chk("f2_y", y4(), 16'h1234);
    step4(0, 0, 0);
    chk("fv_count", fv_cnt, 2);

    // Early sync: 7,8 then 9 with frame_sync.
    step4(1, 1, 4'h7);
    step4(1, 0, 4'h8);
    step4(1, 1, 4'h9);
    chk("early_err", b4.sync_err, 1'b1);
    chk("early_sel", b4.sel, 2'd1);
    chk("early_fv", b4.frame_valid, 1'b0);
    chk("early_held", y4(), 16'h1234);
    step4(1, 0, 4'hA);
    chk("early_err_off", b4.sync_err, 1'b0);
    step4(1, 0, 4'hB);
    step4(1, 0, 4'hC);
    chk("early_y", y4(), 16'h9ABC);

    // Missing sync after a complete frame.
    step4(1, 0, 4'hD);
    chk("miss_err", b4.sync_err, 1'b1);
    chk("miss_sel", b4.sel, 2'd0);
    step4(1, 0, 4'hE);
    step4(1, 0, 4'hF);
    chk("miss_quiet", b4.sync_err, 1'b0);
    step4(1, 0, 4'h1);
    chk("miss_y", y4(), 16'h9ABC);
    step4(1, 1, 4'h2); step4(1, 0, 4'h3); step4(1, 0, 4'h4); step4(1, 0, 4'h5);
    chk("resync_y", y4(), 16'h2345);

    // Reset after two samples of a frame; outputs clear with no clock edge.
    step4(1, 1, 4'h6);
    step4(1, 0, 4'h7);
    rst_n = 1'b0;
    #1;
    chk("async_y", y4(), 16'h0000);
    chk("async_sel", b4.sel, 2'd0);
    step4(0, 0, 0);
    rst_n = 1'b1;
    step4(0, 0, 0); step4(0, 0, 0); step4(0, 0, 0);
    step4(1, 0, 4'h8);
    chk("post_rst_hunt", b4.sel, 2'd0);
    step4(1, 0, 4'hE);
    chk("post_rst_idle", y4(), 16'h0000);
    step4(1, 1, 4'h8); step4(1, 0, 4'h4); step4(1, 0, 4'h2); step4(1, 0, 4'h1);
    chk("post_rst_y", y4(), 16'h8421);
    chk("post_rst_fv", b4.frame_valid, 1'b1);

    chk("fv_err_excl", excl_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
